cio_arbiter: RTL and testbench

CIO_ARBITER -- requirements
Module: cio_arbiter

---
 rtl/cio_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/cio_arbiter.sv | 143 ++++++++++++++
 tb/tb_cio_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cio_pkg.sv
// Shared types and constants for the DekatronPC console I/O arbiter.
package cio_pkg;

  localparam int CHAR_WIDTH  = 8;
  localparam int DEF_SINKS   = 2;
  localparam int DEF_SOURCES = 2;

  typedef enum logic [2:0] {
    IDLE,
    OUT_BCAST,
    IN_GRANT,
    ACK,
    RELEASE
  } cio_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer wins.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]                      req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                      grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] idx;
  logic          found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int j = 0; j < N; j++) begin
      idx = PW'((int'(ptr) + j) % N);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cio_arbiter.sv
// Console I/O arbiter: broadcasts DekatronPC output to all enabled sinks and
// serves input requests from sources round-robin. CIO_TIMEOUT_EN adds a sink ack timeout.
module cio_arbiter
  import cio_pkg::*;
#(
  parameter int SINKS          = DEF_SINKS,
  parameter int SOURCES        = DEF_SOURCES,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          Cout,
  input  logic [CHAR_WIDTH-1:0]         stdout,
  input  logic                          CinReq,
  output logic                          CioAcq,
  output logic [CHAR_WIDTH-1:0]         stdin,
  input  logic [SINKS-1:0]              sink_en,
  output logic [SINKS-1:0]              sink_req,
  input  logic [SINKS-1:0]              sink_acq,
  output logic [CHAR_WIDTH-1:0]         sink_data,
  input  logic [SOURCES-1:0]            src_valid,
  input  logic [CHAR_WIDTH*SOURCES-1:0] src_data,
  output logic [SOURCES-1:0]            src_ready,
  output logic                          timeout_flag
);

  localparam int PW = (SOURCES > 1) ? $clog2(SOURCES) : 1;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  cio_state_t              state, state_nxt;
  logic [SINKS-1:0]        active, done, acked;
  logic                    all_done, tmo_hit, in_start;
  logic [SOURCES-1:0]      grant, grant_q;
  logic [PW-1:0]           ptr, grant_idx;
  logic [CHAR_WIDTH-1:0]   grant_char;

  rr_arbiter #(.N(SOURCES)) u_rr (
    .req   (src_valid),
    .ptr   (ptr),
    .grant (grant)
  );

  always_comb begin
    grant_idx  = '0;
    grant_char = '0;
    for (int i = 0; i < SOURCES; i++) begin
      if (grant[i]) begin
        grant_idx  = PW'(i);
        grant_char = src_data[i*CHAR_WIDTH +: CHAR_WIDTH];
      end
    end
  end

`ifdef CIO_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_cnt;
  logic          timeout_q;

  assign tmo_hit      = (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_q;

  // Counter only advances while waiting on sinks and restarts for each character.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else if (state == OUT_BCAST) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      if (tmo_hit && !all_done) timeout_q <= 1'b1;
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit      = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    acked     = done | (sink_acq & active);
    all_done  = ((acked & active) == active);
    in_start  = CinReq && (|src_valid);
    state_nxt = state;
    CioAcq    = 1'b0;
    sink_req  = '0;
    src_ready = '0;
    case (state)
      IDLE: begin
        if (Cout)          state_nxt = OUT_BCAST;
        else if (in_start) state_nxt = IN_GRANT;
      end
      OUT_BCAST: begin
        sink_req = active & ~done;
        if (all_done || tmo_hit) state_nxt = ACK;
      end
      IN_GRANT: begin
        src_ready = grant_q;
        state_nxt = ACK;
      end
      ACK: begin
        CioAcq    = 1'b1;
        state_nxt = RELEASE;
      end
      RELEASE: begin
        if (!Cout && !CinReq) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output wins over input when both are requested in the same IDLE cycle.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      sink_data <= '0;
      active    <= '0;
      done      <= '0;
      stdin     <= '0;
      grant_q   <= '0;
      ptr       <= '0;
    end else begin
      if (state == IDLE && Cout) begin
        sink_data <= stdout;
        active    <= sink_en;
        done      <= '0;
      end else if (state == IDLE && in_start) begin
        stdin   <= grant_char;
        grant_q <= grant;
        ptr     <= (grant_idx == PW'(SOURCES - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == OUT_BCAST) done <= tmo_hit ? active : acked;
    end
  end

endmodule

// File: tb/tb_cio_arbiter.sv
// Randomized self-checking bench for cio_arbiter against a transaction-level model.
module tb_cio_arbiter;

`ifdef CIO_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1000000;
`endif

  logic        clk, rst, cout, cin_req, cio_acq, timeout_flag;
  logic [7:0]  out_char, in_char, sink_data;
  logic [1:0]  sink_en, sink_req, sink_acq, src_valid, src_ready;
  logic [15:0] src_data;

  int         tests = 0;
  int         failures = 0;
  int         ptr_model = 0;
  logic [7:0] stdin_model = '0;

  cio_arbiter #(.SINKS(2), .SOURCES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk          (clk),
    .Rst          (rst),
    .Cout         (cout),
    .stdout       (out_char),
    .CinReq       (cin_req),
    .CioAcq       (cio_acq),
    .stdin        (in_char),
    .sink_en      (sink_en),
    .sink_req     (sink_req),
    .sink_acq     (sink_acq),
    .sink_data    (sink_data),
    .src_valid    (src_valid),
    .src_data     (src_data),
    .src_ready    (src_ready),
    .timeout_flag (timeout_flag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset;
    rst = 1'b1;
    cout = 1'b0;
    cin_req = 1'b0;
    sink_acq = '0;
    tick();
    rst = 1'b0;
    ptr_model = 0;
    stdin_model = '0;
    checkOutput("rst_cio_acq", 32'(cio_acq), 32'd0);
    checkOutput("rst_sink_req", 32'(sink_req), 32'd0);
    checkOutput("rst_src_ready", 32'(src_ready), 32'd0);
    checkOutput("rst_sink_data", 32'(sink_data), 32'd0);
    checkOutput("rst_stdin", 32'(in_char), 32'd0);
    checkOutput("rst_timeout_flag", 32'(timeout_flag), 32'd0);
  endtask

  // a0/a1: cycles after the request edge at which each sink acknowledges.
  task automatic runOutput(input logic [7:0] c, input logic [1:0] en, input int a0,
                           input int a1, input int hold, input logic with_cin);
    int a[2];
    int last;
    logic [1:0] exp_req;
    a[0] = a0;
    a[1] = a1;
    last = 1;
    for (int i = 0; i < 2; i++) if (en[i] && a[i] > last) last = a[i];
    out_char = c;
    sink_en = en;
    sink_acq = '0;
    cout = 1'b1;
    cin_req = with_cin;
    for (int k = 0; k <= last + hold; k++) begin
      tick();
      for (int i = 0; i < 2; i++) exp_req[i] = en[i] && (k < a[i]);
      checkOutput("out_sink_req", 32'(sink_req), 32'(exp_req));
      checkOutput("out_cio_acq", 32'(cio_acq), 32'(k == last));
      checkOutput("out_sink_data", 32'(sink_data), 32'(c));
      checkOutput("out_src_ready", 32'(src_ready), 32'd0);
      checkOutput("out_stdin_held", 32'(in_char), 32'(stdin_model));
      if (k >= last + hold) begin
        cout = 1'b0;
        cin_req = 1'b0;
      end
      for (int i = 0; i < 2; i++)
        sink_acq[i] = en[i] ? ((k + 1 == a[i]) || (k + 1 > a[i] && $urandom_range(1) == 1))
                            : ($urandom_range(1) == 1);
      sink_en = 2'($urandom);
      out_char = 8'($urandom);
    end
    sink_acq = '0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("out_drain_cio_acq", 32'(cio_acq), 32'd0);
      checkOutput("out_drain_sink_req", 32'(sink_req), 32'd0);
      checkOutput("out_timeout_flag", 32'(timeout_flag), 32'd0);
    end
  endtask

  task automatic runInput(input logic [1:0] valid, input logic [15:0] data, input int hold);
    int g;
    logic [7:0] exp_char;
    cout = 1'b0;
    cin_req = 1'b1;
    src_valid = valid;
    src_data = data;
    if (valid == 2'b00) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        checkOutput("in_empty_cio_acq", 32'(cio_acq), 32'd0);
        checkOutput("in_empty_src_ready", 32'(src_ready), 32'd0);
      end
      cin_req = 1'b0;
      tick();
      return;
    end
    g = -1;
    for (int j = 0; j < 2; j++)
      if (g < 0 && valid[(ptr_model + j) % 2]) g = (ptr_model + j) % 2;
    exp_char = data[8*g +: 8];
    ptr_model = (g + 1) % 2;
    stdin_model = exp_char;
    tick();
    checkOutput("in_src_ready", 32'(src_ready), 32'(1 << g));
    checkOutput("in_stdin", 32'(in_char), 32'(exp_char));
    checkOutput("in_grant_cio_acq", 32'(cio_acq), 32'd0);
    src_data = 16'($urandom);
    src_valid = 2'($urandom);
    tick();
    checkOutput("in_cio_acq", 32'(cio_acq), 32'd1);
    checkOutput("in_ack_src_ready", 32'(src_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      tick();
      checkOutput("in_hold_cio_acq", 32'(cio_acq), 32'd0);
      checkOutput("in_hold_src_ready", 32'(src_ready), 32'd0);
    end
    cin_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checkOutput("in_drain_cio_acq", 32'(cio_acq), 32'd0);
      checkOutput("in_drain_stdin", 32'(in_char), 32'(stdin_model));
    end
  endtask

  task automatic applyStimulus;
    int kind;
    kind = $urandom_range(2);
    if (kind == 0)
      runOutput(8'($urandom), 2'($urandom), $urandom_range(1, 6), $urandom_range(1, 6),
                $urandom_range(3), 1'b0);
    else if (kind == 1)
      runInput(2'($urandom), 16'($urandom), $urandom_range(3));
    else begin
      runOutput(8'($urandom), 2'($urandom), $urandom_range(1, 6), $urandom_range(1, 6),
                $urandom_range(3), 1'b1);
      runInput(2'($urandom_range(1, 3)), 16'($urandom), $urandom_range(3));
    end
  endtask

  initial begin
    rst = 1'b0;
    cout = 1'b0;
    cin_req = 1'b0;
    out_char = '0;
    sink_en = '0;
    sink_acq = '0;
    src_valid = '0;
    src_data = '0;
    doReset();

    runOutput(8'h41, 2'b11, 3, 7, 0, 1'b0);
    runOutput(8'h5a, 2'b00, 1, 1, 1, 1'b0);
    runInput(2'b11, 16'h3231, 0);
    runInput(2'b11, 16'h3231, 1);
    runInput(2'b11, 16'h3231, 0);
    runOutput(8'h21, 2'b01, 2, 1, 0, 1'b1);
    runInput(2'b10, 16'h3433, 2);
    runInput(2'b00, 16'h0000, 0);

    // Reset while sinks are still being waited on.
    out_char = 8'h66;
    sink_en = 2'b11;
    cout = 1'b1;
    tick();
    checkOutput("mid_sink_req", 32'(sink_req), 32'd3);
    tick();
    rst = 1'b1;
    cout = 1'b0;
    tick();
    rst = 1'b0;
    ptr_model = 0;
    stdin_model = '0;
    checkOutput("mid_rst_sink_req", 32'(sink_req), 32'd0);
    checkOutput("mid_rst_sink_data", 32'(sink_data), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("mid_rst_cio_acq", 32'(cio_acq), 32'd0);
    end
    runInput(2'b11, 16'h3837, 0);

`ifdef CIO_TIMEOUT_EN
    out_char = 8'h7e;
    sink_en = 2'b11;
    sink_acq = '0;
    cout = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      tick();
      checkOutput("tmo_sink_req", 32'(sink_req), 32'({k < 16, k < 2}));
      checkOutput("tmo_cio_acq", 32'(cio_acq), 32'(k == 16));
      checkOutput("tmo_flag", 32'(timeout_flag), 32'(k >= 16));
      sink_acq = {1'b0, k + 1 == 2};
    end
    cout = 1'b0;
    sink_acq = '0;
    tick();
    tick();
    checkOutput("tmo_flag_sticky", 32'(timeout_flag), 32'd1);
    doReset();
`endif

    for (int n = 0; n < 40; n++) applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
